// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-address generator.
//   DefaultBusWidth : default fetch address width
//   DefaultResetPc  : default first fetch address after reset
//   PcStep          : sequential fetch stride in bytes
//   state_e         : one-hot request-tracking states
package pc_gen_pkg;

  localparam int unsigned DefaultBusWidth = 32;
  localparam logic [31:0] DefaultResetPc  = 32'h0000_0000;
  localparam int unsigned PcStep          = 4;

  // StIdle: post-reset bubble; StReq: request being offered to the ROM;
  // StAck: ROM accepted the address, waiting for pre-IF to take it.
  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StReq  = 3'b010,
    StAck  = 3'b100
  } state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Bundle of every non-clock signal around pc_gen.
//   Control in : hold_pc, redirect_valid, redirect_pc
//   ROM side   : mem_req, mem_addr (out of pc_gen), mem_addr_ok (in)
//   pre-IF side: valid_pre, ready_go_pre, next_pc, cancel_if (out), allow_in_if (in)
// master = pc_gen itself, slave = everything around it.
interface pc_gen_if #(
  parameter int unsigned BUS_WIDTH = 32
) ();

  logic                 hold_pc;
  logic                 redirect_valid;
  logic [BUS_WIDTH-1:0] redirect_pc;

  logic                 mem_req;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic                 mem_addr_ok;

  logic                 valid_pre;
  logic                 ready_go_pre;
  logic [BUS_WIDTH-1:0] next_pc;
  logic                 allow_in_if;
  logic                 cancel_if;

  modport master (
    input  hold_pc,
    input  redirect_valid,
    input  redirect_pc,
    output mem_req,
    output mem_addr,
    input  mem_addr_ok,
    output valid_pre,
    output ready_go_pre,
    output next_pc,
    input  allow_in_if,
    output cancel_if
  );

  modport slave (
    output hold_pc,
    output redirect_valid,
    output redirect_pc,
    input  mem_req,
    input  mem_addr,
    output mem_addr_ok,
    input  valid_pre,
    input  ready_go_pre,
    input  next_pc,
    output allow_in_if,
    input  cancel_if
  );

endinterface

// File: rtl/pc_gen.sv
// Fetch-address generator feeding the pre-IF stage.
// Holds the architectural fetch PC, issues one ROM address request at a time,
// hands each accepted request to pre-IF, absorbs redirects and cancels any
// already-accepted request that turns out to be wrong-path.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : pc_gen_if.master (ROM request, pre-IF handshake, redirect/hold in)
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH = DefaultBusWidth,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = BUS_WIDTH'(DefaultResetPc)
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.master bus
);

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] pc_q, pc_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [BUS_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                 stale_q, stale_d;
  logic                 drop_q, drop_d;

  logic                 mem_req;
  logic                 valid_pre;
  logic                 ready_go_pre;
  logic                 handoff;
  logic [BUS_WIDTH-1:0] redirect_tgt;
  logic [BUS_WIDTH-1:0] adv_pc;

  // Redirect targets are word-aligned; the low bits are simply discarded.
  assign redirect_tgt = {bus.redirect_pc[BUS_WIDTH-1:2], 2'b00};

  // Address taken on handoff: a live redirect wins, then a buffered one,
  // otherwise sequential (wraps naturally at the top of the address space).
  always_comb begin
    if (bus.redirect_valid) begin
      adv_pc = redirect_tgt;
    end else if (pend_valid_q) begin
      adv_pc = pend_pc_q;
    end else begin
      adv_pc = pc_q + BUS_WIDTH'(PcStep);
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    stale_d      = stale_q;
    drop_d       = 1'b0;
    mem_req      = 1'b0;
    valid_pre    = 1'b0;
    ready_go_pre = 1'b0;
    handoff      = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (bus.redirect_valid) begin
          pc_d = redirect_tgt;
        end
      end

      StReq: begin
        valid_pre = 1'b1;
        // A redirect suppresses the request so nothing wrong-path is accepted.
        mem_req      = !bus.hold_pc && !bus.redirect_valid;
        ready_go_pre = mem_req && bus.mem_addr_ok;
        handoff      = ready_go_pre && bus.allow_in_if;
        if (bus.redirect_valid) begin
          pc_d = redirect_tgt;
        end else if (ready_go_pre && !bus.allow_in_if) begin
          state_d = StAck;
        end
      end

      StAck: begin
        valid_pre    = 1'b1;
        ready_go_pre = 1'b1;
        handoff      = bus.allow_in_if;
        if (handoff) begin
          state_d = StReq;
        end else if (bus.redirect_valid) begin
          // Address already accepted: keep it stable for pre-IF, remember the
          // target and mark the outstanding fetch as wrong-path.
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_tgt;
          stale_d      = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (handoff) begin
      pc_d         = adv_pc;
      pend_valid_d = 1'b0;
      stale_d      = 1'b0;
      // The fetch just handed over is wrong-path if it was marked stale or a
      // redirect arrives in the very cycle it is handed over.
      drop_d       = stale_q || bus.redirect_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      stale_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      stale_q      <= stale_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.mem_req      = mem_req;
  assign bus.mem_addr     = pc_q;
  assign bus.valid_pre    = valid_pre;
  assign bus.ready_go_pre = ready_go_pre;
  assign bus.next_pc      = pc_q;
  assign bus.cancel_if    = bus.redirect_valid || drop_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural fetch model.
module tb_pc_gen;

  logic clk;
  logic rst;

  pc_gen_if #(.BUS_WIDTH(32)) bus ();
  pc_gen_if #(.BUS_WIDTH(32)) wbus ();

  pc_gen #(
    .BUS_WIDTH(32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Second instance exercising the address wrap from the top of memory.
  pc_gen #(
    .BUS_WIDTH(32),
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_wrap (
    .clk(clk),
    .rst(rst),
    .bus(wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model: tracks whether a fetch is owned, whether its address
  // was accepted, whether it is wrong-path and the newest buffered redirect.
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  bit          m_idle;
  bit          m_acc;
  bit          m_wrong;
  bit          m_cancel_next;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];

  // Snapshot of the last sampled cycle, for directed checks.
  logic        s_mem_req, s_valid, s_ready, s_cancel, s_handoff, s_w_handoff;
  logic [31:0] s_addr, s_next_pc, s_w_next_pc;

  task automatic model_reset();
    m_idle        = 1'b1;
    m_acc         = 1'b0;
    m_wrong       = 1'b0;
    m_cancel_next = 1'b0;
    m_pc          = ResetPc;
    m_pend.delete();
  endtask

  // One clock: sample at negedge, compare, advance model, step past posedge.
  task automatic step();
    logic        e_req, e_valid, e_ready, e_cancel, ho;
    logic [31:0] tgt;
    @(negedge clk);
    tgt = {bus.redirect_pc[31:2], 2'b00};
    if (m_idle) begin
      e_valid = 1'b0; e_req = 1'b0; e_ready = 1'b0;
    end else if (!m_acc) begin
      e_valid = 1'b1;
      e_req   = !bus.hold_pc && !bus.redirect_valid;
      e_ready = e_req && bus.mem_addr_ok;
    end else begin
      e_valid = 1'b1; e_req = 1'b0; e_ready = 1'b1;
    end
    e_cancel = bus.redirect_valid || m_cancel_next;

    check_eq("mem_req",      32'(bus.mem_req),      32'(e_req));
    check_eq("valid_pre",    32'(bus.valid_pre),    32'(e_valid));
    check_eq("ready_go_pre", 32'(bus.ready_go_pre), 32'(e_ready));
    check_eq("cancel_if",    32'(bus.cancel_if),    32'(e_cancel));
    check_eq("mem_addr",     bus.mem_addr,          m_pc);
    check_eq("next_pc",      bus.next_pc,           m_pc);

    s_mem_req   = bus.mem_req;
    s_valid     = bus.valid_pre;
    s_ready     = bus.ready_go_pre;
    s_cancel    = bus.cancel_if;
    s_addr      = bus.mem_addr;
    s_next_pc   = bus.next_pc;
    s_handoff   = bus.valid_pre && bus.ready_go_pre && bus.allow_in_if;
    s_w_next_pc = wbus.next_pc;
    s_w_handoff = wbus.valid_pre && wbus.ready_go_pre && wbus.allow_in_if;

    ho = e_valid && e_ready && bus.allow_in_if;
    if (rst) begin
      model_reset();
    end else if (m_idle) begin
      m_idle        = 1'b0;
      m_cancel_next = 1'b0;
      if (bus.redirect_valid) m_pc = tgt;
    end else if (ho) begin
      m_cancel_next = bus.redirect_valid || m_wrong;
      if (bus.redirect_valid)   m_pc = tgt;
      else if (m_pend.size > 0) m_pc = m_pend[$];
      else                      m_pc = m_pc + 32'd4;
      m_pend.delete();
      m_wrong = 1'b0;
      m_acc   = 1'b0;
    end else begin
      m_cancel_next = 1'b0;
      if (!m_acc && bus.redirect_valid) begin
        m_pc = tgt;
      end else if (m_acc && bus.redirect_valid) begin
        m_pend.push_back(tgt);
        m_wrong = 1'b1;
      end else if (!m_acc && e_ready) begin
        m_acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic hold, input logic rv, input logic [31:0] rpc,
                       input logic ok, input logic allow);
    bus.hold_pc        = hold;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.mem_addr_ok    = ok;
    bus.allow_in_if    = allow;
  endtask

  initial begin
    wbus.hold_pc        = 1'b0;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = 32'h0;
    wbus.mem_addr_ok    = 1'b1;
    wbus.allow_in_if    = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    step();  // reset still high: outputs now hold reset values

    // Reset release, free-flowing fetch.
    rst = 1'b0;
    step();
    check_eq("first_req_c1", 32'(s_mem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("seq_handoff", 32'(s_handoff), 32'd1);
      check_eq("seq_next_pc", s_next_pc, 32'(i * 4));
      check_eq("seq_cancel",  32'(s_cancel), 32'd0);
      if (i == 0) begin
        check_eq("first_req_c2", 32'(s_mem_req), 32'd1);
        check_eq("wrap_pc0", s_w_next_pc, 32'hFFFF_FFFC);
      end
      if (i == 1) begin
        check_eq("wrap_handoff", 32'(s_w_handoff), 32'd1);
        check_eq("wrap_pc1", s_w_next_pc, 32'h0000_0000);
      end
    end

    // ROM stalls at 0x10.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_addr",  s_addr, 32'h10);
      check_eq("stall_ready", 32'(s_ready), 32'd0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    check_eq("stall_handoff", 32'(s_handoff), 32'd1);
    check_eq("stall_pc",      s_next_pc, 32'h10);

    // Redirect while an accepted request waits for pre-IF.
    step(); step(); step();  // 0x14, 0x18, 0x1C
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();  // 0x20 accepted, not taken
    drive(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    step();
    check_eq("ack_redir_cancel", 32'(s_cancel), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    check_eq("stale_handoff", 32'(s_handoff), 32'd1);
    check_eq("stale_pc",      s_next_pc, 32'h20);
    step();
    check_eq("drop_cancel", 32'(s_cancel), 32'd1);
    check_eq("redir_addr",  s_addr, 32'h100);
    check_eq("redir_req",   32'(s_mem_req), 32'd1);

    // Redirect in StReq with an unaligned target.
    drive(1'b0, 1'b1, 32'h203, 1'b1, 1'b1);
    step();
    check_eq("req_redir_mem_req", 32'(s_mem_req), 32'd0);
    check_eq("req_redir_cancel",  32'(s_cancel), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    check_eq("req_redir_addr",   s_addr, 32'h200);
    check_eq("req_redir_cancel2", 32'(s_cancel), 32'd0);

    // Hazard hold in StReq, then in StAck.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("hold_req",   32'(s_mem_req), 32'd0);
      check_eq("hold_valid", 32'(s_valid), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step();
    check_eq("hold_ack_handoff", 32'(s_handoff), 32'd1);

    // Reset in the middle of StAck.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check_eq("rst_mid_valid", 32'(s_valid), 32'd0);
    check_eq("rst_mid_pc",    s_next_pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(7) == 0), $urandom(),
            ($urandom_range(3) != 0), ($urandom_range(3) != 0));
      rst = ($urandom_range(199) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
